// File: rtl/mgt_01_f_wb_arbiter.sv
// mgt_01_f_wb_arbiter: FP register file write-back arbiter.
// Round-robin grant of the single write port plus a pending-write scoreboard.
module mgt_01_f_wb_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int N_REGS = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clk_en_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_faddr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_fdata_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      issue_valid_i,
  input  logic [ADDR_W-1:0]         issue_faddr_i,
  output logic                      issue_stall_o,
  input  logic [ADDR_W-1:0]         r1_faddr_i,
  input  logic [ADDR_W-1:0]         r2_faddr_i,
  input  logic [ADDR_W-1:0]         r3_faddr_i,
  output logic [2:0]                raw_hazard_o,
  output logic                      we_o,
  output logic [ADDR_W-1:0]         w_faddr_o,
  output logic [DATA_W-1:0]         wr_fdata_o,
  output logic [N_REGS-1:0]         busy_o
);

  localparam int PW = $clog2(N_REQ);

  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gidx;
  logic [PW-1:0]     hi_idx;
  logic [PW-1:0]     lo_idx;
  logic [PW-1:0]     nxt_ptr;
  logic              hi_any;
  logic              lo_any;
  logic              grant_en;
  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [N_REGS-1:0] busy_nxt;

  always_comb begin
    for (int k = 0; k < N_REQ; k++) begin
      addr_arr[k] = req_faddr_i[k*ADDR_W +: ADDR_W];
      data_arr[k] = req_fdata_i[k*DATA_W +: DATA_W];
    end
  end

  // Lowest valid index at/after rr_ptr wins; else lowest overall (wrap).
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        lo_idx = PW'(k);
        lo_any = 1'b1;
        if (k >= int'(rr_ptr)) begin
          hi_idx = PW'(k);
          hi_any = 1'b1;
        end
      end
    end
  end

  assign gidx     = hi_any ? hi_idx : lo_idx;
  assign grant_en = lo_any & clk_en_i & ~rst_i;
  assign nxt_ptr  = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);

  assign req_ready_o = grant_en ? ({{(N_REQ-1){1'b0}}, 1'b1} << gidx)
                                : '0;

  assign issue_stall_o = issue_valid_i & busy_o[issue_faddr_i];
  assign raw_hazard_o  = {busy_o[r3_faddr_i],
                          busy_o[r2_faddr_i],
                          busy_o[r1_faddr_i]};

  // Clear first so a same-edge issue to the committed register wins.
  always_comb begin
    busy_nxt = busy_o;
    if (we_o)
      busy_nxt[w_faddr_o] = 1'b0;
    if (issue_valid_i && !issue_stall_o)
      busy_nxt[issue_faddr_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      busy_o     <= '0;
      we_o       <= 1'b0;
      w_faddr_o  <= '0;
      wr_fdata_o <= '0;
    end else if (clk_en_i) begin
      busy_o <= busy_nxt;
      we_o   <= grant_en;
      if (grant_en) begin
        w_faddr_o  <= addr_arr[gidx];
        wr_fdata_o <= data_arr[gidx];
        rr_ptr     <= nxt_ptr;
      end
    end
  end

endmodule

// File: tb/tb_mgt_01_f_wb_arbiter.sv
// tb_mgt_01_f_wb_arbiter: directed bench for the FP write-back arbiter.
// Per-cycle model comparison plus hand-computed literal checks.
module tb_mgt_01_f_wb_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  valid;
  logic [4:0]  fa [N];
  logic [31:0] fd [N];
  logic [19:0] fa_bus;
  logic [127:0] fd_bus;
  logic [3:0]  ready;
  logic        iv;
  logic [4:0]  ia;
  logic        stall;
  logic [4:0]  r1, r2, r3;
  logic [2:0]  raw;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  int total = 0;
  int bad   = 0;

  always_comb begin
    for (int k = 0; k < N; k++) begin
      fa_bus[k*5 +: 5]   = fa[k];
      fd_bus[k*32 +: 32] = fd[k];
    end
  end

  mgt_01_f_wb_arbiter dut (
    .clk_i(clk), .rst_i(rst), .clk_en_i(en),
    .req_valid_i(valid), .req_faddr_i(fa_bus), .req_fdata_i(fd_bus),
    .req_ready_o(ready),
    .issue_valid_i(iv), .issue_faddr_i(ia), .issue_stall_o(stall),
    .r1_faddr_i(r1), .r2_faddr_i(r2), .r3_faddr_i(r3),
    .raw_hazard_o(raw),
    .we_o(we), .w_faddr_o(waddr), .wr_fdata_o(wdata),
    .busy_o(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural model: abstract state in plain ints/bit vectors.
  bit          m_init = 0;
  int          m_ptr;
  bit [31:0]   m_busy;
  bit          m_we;
  bit [4:0]    m_addr;
  bit [31:0]   m_data;

  function automatic int pick(input int ptr);
    for (int i = 0; i < N; i++)
      if (valid[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1;
      m_ptr  = 0;
      m_busy = 0;
      m_we   = 0;
      m_addr = 0;
      m_data = 0;
    end else if (en) begin
      int  g;
      bit  st;
      st = iv && m_busy[ia];
      if (m_we) m_busy[m_addr] = 0;
      if (iv && !st) m_busy[ia] = 1;
      g = pick(m_ptr);
      m_we = (g >= 0);
      if (g >= 0) begin
        m_addr = fa[g];
        m_data = fd[g];
        m_ptr  = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      int       g;
      bit [3:0] er;
      g  = pick(m_ptr);
      er = (!rst && en && g >= 0) ? 4'(1 << g) : 4'b0;
      chk("m_ready", 32'(ready), 32'(er));
      chk("m_stall", 32'(stall), 32'(iv && m_busy[ia]));
      chk("m_raw", 32'(raw), 32'({m_busy[r3], m_busy[r2], m_busy[r1]}));
      chk("m_we", 32'(we), 32'(m_we));
      if (m_we) begin
        chk("m_waddr", 32'(waddr), 32'(m_addr));
        chk("m_wdata", wdata, m_data);
      end
      chk("m_busy", busy, m_busy);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; en = 1; valid = 4'b1111;
    iv = 0; ia = 0; r1 = 0; r2 = 0; r3 = 0;
    for (int k = 0; k < N; k++) begin
      fa[k] = 5'(10 + k);
      fd[k] = 32'hA000_0000 + 32'(k);
    end
    #1;
    chk("rst_ready", 32'(ready), 32'h0);
    step();
    step();
    chk("rst_we", 32'(we), 32'h0);
    chk("rst_busy", busy, 32'h0);

    // Round-robin over all four, wrapping to 0.
    rst = 0;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("rr_ready", 32'(ready), 32'(1 << (i % 4)));
      step();
      chk("rr_we", 32'(we), 32'h1);
      chk("rr_addr", 32'(waddr), 32'(10 + i % 4));
      chk("rr_data", wdata, 32'hA000_0000 + 32'(i % 4));
    end

    // Scoreboard set, RAW, commit from requester 1.
    valid = 0; iv = 1; ia = 5;
    step();
    iv = 0; r2 = 5;
    #1;
    chk("sb_busy5", 32'(busy[5]), 32'h1);
    chk("sb_raw", 32'(raw), 32'b010);
    fa[1] = 5; fd[1] = 32'h3F80_0000; valid = 4'b0010;
    #1;
    chk("sb_ready", 32'(ready), 32'b0010);
    step();
    valid = 0;
    chk("sb_waddr", 32'(waddr), 32'd5);
    chk("sb_wdata", wdata, 32'h3F80_0000);
    chk("sb_raw_hold", 32'(raw), 32'b010);
    step();
    chk("sb_clear", 32'(busy[5]), 32'h0);
    chk("sb_raw_drop", 32'(raw), 32'b000);

    // WAW stall, then same-edge set/clear of f3.
    iv = 1; ia = 7;
    step();
    #1;
    chk("waw_stall", 32'(stall), 32'h1);
    step();
    iv = 0;
    chk("waw_busy", busy, 32'h0000_0080);
    fa[2] = 3; valid = 4'b0100;
    step();
    valid = 0; iv = 1; ia = 3;
    #1;
    chk("same_stall", 32'(stall), 32'h0);
    step();
    iv = 0;
    chk("same_busy", busy, 32'h0000_0088);

    // Requester 3 writes f7 so rr_ptr wraps to 0, then freeze.
    fa[3] = 7; valid = 4'b1000;
    step();
    en = 0; valid = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("frz_ready", 32'(ready), 32'h0);
      chk("frz_we", 32'(we), 32'h1);
      chk("frz_busy", busy, 32'h0000_0088);
      step();
    end
    en = 1;
    #1;
    chk("ren_ready", 32'(ready), 32'b0010);
    step();
    chk("ren_busy", busy, 32'h0000_0008);
    chk("ren_addr", 32'(waddr), 32'd5);

    // Reset one cycle after a grant.
    rst = 1;
    #1;
    chk("mrst_ready", 32'(ready), 32'h0);
    step();
    chk("mrst_we", 32'(we), 32'h0);
    chk("mrst_busy", busy, 32'h0);
    rst = 0;
    #1;
    chk("mrst_ptr", 32'(ready), 32'b0010);
    step();
    valid = 0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
